cd_sram_arb: RTL and testbench
==============================

Name: cd_sram_arb

Overview:
Two-requester arbiter that shares one cd_sram instance between a host-side agent (requester 0, e.g. register/bus interface) and a frame engine (requester 1, e.g. tx serializer / rx deserializer). Read and write ports of the RAM are arbitrated independently, each with its own round-robin pointer. The block returns per-requester read-valid strobes aligned to the RAM's 1-cycle read latency. Requester 1 may lock the read port for burst transfers.

Parameters:
A_WIDTH, 8, RAM address width; must match the attached cd_sram.

Ports:
clk  input  1  single clock for all logic
reset  input  1  asynchronous, active-high reset
rd_req0  input  1  requester 0 read request
rd_addr0  input  A_WIDTH  requester 0 read address
rd_gnt0  output  1  requester 0 read accepted this cycle (combinational)
rd_vld0  output  1  rd_data holds requester 0 data (registered)
rd_req1  input  1  requester 1 read request
rd_addr1  input  A_WIDTH  requester 1 read address
rd_lock1  input  1  requester 1 holds read port while asserted with rd_req1
rd_gnt1  output  1  requester 1 read accepted this cycle
rd_vld1  output  1  rd_data holds requester 1 data
rd_data  output  8  shared read data, valid when rd_vld0 or rd_vld1
wr_req0 / wr_req1  input  1 each  write requests
wr_addr0 / wr_addr1  input  A_WIDTH each  write addresses
wr_data0 / wr_data1  input  8 each  write data
wr_gnt0 / wr_gnt1  output  1 each  write accepted this cycle (combinational)
ram_ra  output  A_WIDTH  to cd_sram ra
ram_re  output  1  to cd_sram re
ram_rd  input  8  from cd_sram rd
ram_wa  output  A_WIDTH  to cd_sram wa
ram_wd  output  8  to cd_sram wd
ram_we  output  1  to cd_sram we

Behaviour:
- Reset (async, active-high): rd_ptr=0, wr_ptr=0, rd_vld0=rd_vld1=0, lock state cleared. Combinational outputs then follow inputs with pointers at 0.
- Pointer semantics: ptr=0 means requester 0 has priority on a conflict; ptr=1 means requester 1 has priority.
- Read arbitration, per cycle:
  - Only one request: granted.
  - Both requesting: the requester selected by rd_ptr wins.
  - After any read grant, rd_ptr <= index of the non-granted requester (round-robin).
  - Neither requesting: no grant, rd_ptr holds.
- Lock: lock_st is set on a cycle with rd_gnt1 && rd_lock1. While lock_st && rd_req1 && rd_lock1, requester 1 wins regardless of rd_ptr and requester 0 is starved. Lock_st clears the first cycle rd_lock1 or rd_req1 is low. On clear, rd_ptr=0, so requester 0 wins the next conflict.
- RAM read drive:
  - ram_re = rd_gnt0 | rd_gnt1.
  - ram_ra = granted address; rd_addr0 when idle. The value is don't-care for function but must be deterministic.
- Read return:
  - rd_vld0 <= rd_gnt0; rd_vld1 <= rd_gnt1 (registered).
  - rd_data = ram_rd, passed through combinationally. Latency from grant to data is exactly 1 cycle.
  - Back-to-back grants give data every cycle. Never both vld high.
- Write arbitration: same round-robin rule with its own wr_ptr. No lock on writes.
  - ram_we = wr_gnt0 | wr_gnt1; ram_wa/ram_wd are muxed from the winner; requester 0 values are driven when idle.
- Handshake: a requester holds req/addr/data stable until it sees gnt high at a clock edge. Dropping req before grant is legal (request withdrawn). gnt never asserts without the matching req in the same cycle.
- Read/write collision: a read and a write to the same address granted in the same cycle return the OLD contents. No forwarding; requesters order themselves.
- Reset mid-operation: an in-flight read (granted in the cycle before reset) is dropped, so no vld is issued after reset. The RAM contents are not touched.
- Fairness bound: with both requesting continuously and no lock, each requester is granted at least once every 2 cycles.

Test Plan:
- Post-reset, rd_req0=rd_req1=1 held, no lock -> grants alternate 0,1,0,1. rd_vld alternates one cycle later. rd_data matches preloaded ram[addr].
- Write 0xA5 to 0x10 via wr_req1, then read 0x10 via rd_req0 next cycle -> rd_gnt0 same cycle; rd_vld0=1 next cycle with rd_data=0xA5.
- Same-cycle write 0x3C to 0x20 (old 0x11) and read 0x20 -> read returns 0x11; a read the following cycle returns 0x3C.
- rd_req0 held, requester 1 locks for 4 reads (0x40..0x43) -> rd_gnt1 4 consecutive cycles, rd_gnt0=0 throughout. Lock drops -> rd_gnt0 on the next cycle.
- Both writers active for 6 cycles with distinct data -> 3 grants each, alternating. Readback confirms last writer data per address.
- Assert reset the cycle after rd_gnt1 -> rd_vld1 stays 0. After release, rd_ptr=0 and the first conflict grants requester 0.

Source files
------------

// File: rtl/cd_sram_arb.sv
// cd_sram_arb: two-requester round-robin arbiter for the cd_sram read and write ports,
// with read-valid strobes aligned to the 1-cycle RAM read latency and a requester-1 read lock.
module cd_sram_arb #(
    parameter int A_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rd_req0,
    input  logic [A_WIDTH-1:0] rd_addr0,
    output logic               rd_gnt0,
    output logic               rd_vld0,
    input  logic               rd_req1,
    input  logic [A_WIDTH-1:0] rd_addr1,
    input  logic               rd_lock1,
    output logic               rd_gnt1,
    output logic               rd_vld1,
    output logic [7:0]         rd_data,
    input  logic               wr_req0,
    input  logic [A_WIDTH-1:0] wr_addr0,
    input  logic [7:0]         wr_data0,
    output logic               wr_gnt0,
    input  logic               wr_req1,
    input  logic [A_WIDTH-1:0] wr_addr1,
    input  logic [7:0]         wr_data1,
    output logic               wr_gnt1,
    output logic [A_WIDTH-1:0] ram_ra,
    output logic               ram_re,
    input  logic [7:0]         ram_rd,
    output logic [A_WIDTH-1:0] ram_wa,
    output logic [7:0]         ram_wd,
    output logic               ram_we
);
    typedef enum logic {UNLOCKED, LOCKED} lock_t;
    lock_t lock_q, lock_d;
    logic  rd_ptr_q, rd_ptr_d;
    logic  wr_ptr_q, wr_ptr_d;
    logic  rd_vld0_q, rd_vld1_q;
    logic  lock_win;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q    <= UNLOCKED;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            rd_vld0_q <= 1'b0;
            rd_vld1_q <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_vld0_q <= rd_gnt0;
            rd_vld1_q <= rd_gnt1;
        end
    end
    // A held lock overrides the pointer; every requester-1 grant leaves the pointer at 0,
    // so requester 0 wins the first conflict once the lock drops.
    always_comb begin
        lock_win = (lock_q == LOCKED) && rd_req1 && rd_lock1;
        rd_gnt1  = rd_req1 & (lock_win | ~rd_req0 | rd_ptr_q);
        rd_gnt0  = rd_req0 & ~rd_gnt1;
        rd_ptr_d = rd_gnt0 ? 1'b1 : rd_gnt1 ? 1'b0 : rd_ptr_q;
        lock_d   = (rd_req1 && rd_lock1 && (lock_win || rd_gnt1)) ? LOCKED : UNLOCKED;
        wr_gnt1  = wr_req1 & (~wr_req0 | wr_ptr_q);
        wr_gnt0  = wr_req0 & ~wr_gnt1;
        wr_ptr_d = wr_gnt0 ? 1'b1 : wr_gnt1 ? 1'b0 : wr_ptr_q;
    end
    assign ram_re  = rd_gnt0 | rd_gnt1;
    assign ram_ra  = rd_gnt1 ? rd_addr1 : rd_addr0;
    assign ram_we  = wr_gnt0 | wr_gnt1;
    assign ram_wa  = wr_gnt1 ? wr_addr1 : wr_addr0;
    assign ram_wd  = wr_gnt1 ? wr_data1 : wr_data0;
    assign rd_vld0 = rd_vld0_q;
    assign rd_vld1 = rd_vld1_q;
    assign rd_data = ram_rd;
endmodule

// File: tb/tb_cd_sram_arb.sv
// tb_cd_sram_arb: directed vector table plus hand-written reset sequences for cd_sram_arb,
// driving a behavioural 1-cycle-latency cd_sram model.
module tb_cd_sram_arb;
    logic       clk = 1'b0;
    logic       reset;
    logic       rd_req0, rd_req1, rd_lock1, rd_gnt0, rd_gnt1, rd_vld0, rd_vld1;
    logic [7:0] rd_addr0, rd_addr1, rd_data;
    logic       wr_req0, wr_req1, wr_gnt0, wr_gnt1;
    logic [7:0] wr_addr0, wr_addr1, wr_data0, wr_data1;
    logic [7:0] ram_ra, ram_rd, ram_wa, ram_wd;
    logic       ram_re, ram_we;
    logic [7:0] mem [256];
    logic       loaded = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    cd_sram_arb #(.A_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .rd_req0(rd_req0), .rd_addr0(rd_addr0), .rd_gnt0(rd_gnt0), .rd_vld0(rd_vld0),
        .rd_req1(rd_req1), .rd_addr1(rd_addr1), .rd_lock1(rd_lock1), .rd_gnt1(rd_gnt1),
        .rd_vld1(rd_vld1), .rd_data(rd_data),
        .wr_req0(wr_req0), .wr_addr0(wr_addr0), .wr_data0(wr_data0), .wr_gnt0(wr_gnt0),
        .wr_req1(wr_req1), .wr_addr1(wr_addr1), .wr_data1(wr_data1), .wr_gnt1(wr_gnt1),
        .ram_ra(ram_ra), .ram_re(ram_re), .ram_rd(ram_rd),
        .ram_wa(ram_wa), .ram_wd(ram_wd), .ram_we(ram_we)
    );

    // Preload: ram[a] = a + 0x80, except ram[0x20] = 0x11. Read-before-write gives old data.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= (i == 32) ? 8'h11 : 8'(i + 128);
            ram_rd <= 8'h00;
            loaded <= 1'b1;
        end else begin
            if (ram_re) ram_rd <= mem[ram_ra];
            if (ram_we) mem[ram_wa] <= ram_wd;
        end
    end

    typedef struct {
        logic       rq0; logic [7:0] ra0; logic rq1; logic [7:0] ra1; logic lk;
        logic       wq0; logic [7:0] wa0; logic [7:0] wd0;
        logic       wq1; logic [7:0] wa1; logic [7:0] wd1;
        logic       g0, g1, wg0, wg1, v0, v1;
        logic [7:0] d;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rq0, input logic [7:0] ra0, input logic rq1, input logic [7:0] ra1, input logic lk,
        input logic wq0, input logic [7:0] wa0, input logic [7:0] wd0,
        input logic wq1, input logic [7:0] wa1, input logic [7:0] wd1,
        input logic g0, input logic g1, input logic wg0, input logic wg1,
        input logic v0, input logic v1, input logic [7:0] d);
        vec_t v;
        v.rq0 = rq0; v.ra0 = ra0; v.rq1 = rq1; v.ra1 = ra1; v.lk = lk;
        v.wq0 = wq0; v.wa0 = wa0; v.wd0 = wd0; v.wq1 = wq1; v.wa1 = wa1; v.wd1 = wd1;
        v.g0 = g0; v.g1 = g1; v.wg0 = wg0; v.wg1 = wg1; v.v0 = v0; v.v1 = v1; v.d = d;
        return v;
    endfunction

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask

    task automatic idle();
        rd_req0 = 0; rd_req1 = 0; rd_lock1 = 0; wr_req0 = 0; wr_req1 = 0;
        rd_addr0 = 0; rd_addr1 = 0; wr_addr0 = 0; wr_addr1 = 0; wr_data0 = 0; wr_data1 = 0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        //                 rq0 ra0    rq1 ra1    lk  wq0 wa0    wd0    wq1 wa1    wd1    g0 g1 wg0 wg1 v0 v1 d
        vecs.push_back(mk(1, 8'h01, 1, 8'h02, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'h01, 1, 8'h02, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1, 0, 8'h81));
        vecs.push_back(mk(1, 8'h01, 1, 8'h02, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1, 8'h82));
        vecs.push_back(mk(1, 8'h01, 1, 8'h02, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1, 0, 8'h81));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 8'h82));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 8'h10, 8'hA5, 0, 0, 0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'h10, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 8'hA5));
        vecs.push_back(mk(0, 8'h00, 1, 8'h20, 0, 1, 8'h20, 8'h3C, 0, 8'h00, 8'h00, 0, 1, 1, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 1, 8'h20, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 1, 8'h11));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 8'h3C));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 8'h30, 8'hC1, 1, 8'h31, 8'hB1, 0, 0, 0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 8'h30, 8'hC1, 1, 8'h31, 8'hB2, 0, 0, 1, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 8'h30, 8'hC2, 1, 8'h31, 8'hB2, 0, 0, 0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 8'h30, 8'hC2, 1, 8'h31, 8'hB3, 0, 0, 1, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 8'h30, 8'hC3, 1, 8'h31, 8'hB3, 0, 0, 0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 1, 8'h30, 8'hC3, 1, 8'h31, 8'hB4, 0, 0, 1, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'h30, 1, 8'h31, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 8'h00, 1, 8'h31, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1, 0, 8'hC3));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 8'hB3));
        vecs.push_back(mk(1, 8'h05, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 8'h05, 1, 8'h40, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1, 0, 8'h85));
        vecs.push_back(mk(1, 8'h05, 1, 8'h41, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 1, 8'hC0));
        vecs.push_back(mk(1, 8'h05, 1, 8'h42, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 1, 8'hC1));
        vecs.push_back(mk(1, 8'h05, 1, 8'h43, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 1, 8'hC2));
        vecs.push_back(mk(1, 8'h05, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1, 8'hC3));
        vecs.push_back(mk(0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 8'h85));

        // Reset state: pointers at 0, so requester 0 wins both conflicts; no valids.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rd_req0 = 1; rd_req1 = 1; wr_req0 = 1; wr_req1 = 1;
        #1;
        chk("rst_vld0", 8'(rd_vld0), 8'h00);
        chk("rst_vld1", 8'(rd_vld1), 8'h00);
        chk("rst_rg0", 8'(rd_gnt0), 8'h01);
        chk("rst_rg1", 8'(rd_gnt1), 8'h00);
        chk("rst_wg0", 8'(wr_gnt0), 8'h01);
        chk("rst_wg1", 8'(wr_gnt1), 8'h00);
        idle();
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            rd_req0 = vecs[i].rq0; rd_addr0 = vecs[i].ra0;
            rd_req1 = vecs[i].rq1; rd_addr1 = vecs[i].ra1; rd_lock1 = vecs[i].lk;
            wr_req0 = vecs[i].wq0; wr_addr0 = vecs[i].wa0; wr_data0 = vecs[i].wd0;
            wr_req1 = vecs[i].wq1; wr_addr1 = vecs[i].wa1; wr_data1 = vecs[i].wd1;
            #1;
            chk($sformatf("v%0d_rg0", i), 8'(rd_gnt0), 8'(vecs[i].g0));
            chk($sformatf("v%0d_rg1", i), 8'(rd_gnt1), 8'(vecs[i].g1));
            chk($sformatf("v%0d_wg0", i), 8'(wr_gnt0), 8'(vecs[i].wg0));
            chk($sformatf("v%0d_wg1", i), 8'(wr_gnt1), 8'(vecs[i].wg1));
            chk($sformatf("v%0d_vld0", i), 8'(rd_vld0), 8'(vecs[i].v0));
            chk($sformatf("v%0d_vld1", i), 8'(rd_vld1), 8'(vecs[i].v1));
            if (vecs[i].v0 || vecs[i].v1) chk($sformatf("v%0d_data", i), rd_data, vecs[i].d);
        end

        // Reset lands on the edge that would register the requester-1 read valid.
        @(negedge clk);
        idle();
        rd_req1 = 1; rd_addr1 = 8'h07;
        #1;
        chk("inflight_gnt1", 8'(rd_gnt1), 8'h01);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("inflight_vld1", 8'(rd_vld1), 8'h00);
        @(negedge clk);
        idle();
        reset = 1'b0;
        #1;
        chk("post_rst_vld1", 8'(rd_vld1), 8'h00);
        @(negedge clk);
        rd_req0 = 1; rd_addr0 = 8'h08; rd_req1 = 1; rd_addr1 = 8'h09;
        #1;
        chk("post_rst_g0", 8'(rd_gnt0), 8'h01);
        chk("post_rst_g1", 8'(rd_gnt1), 8'h00);

        // Pointer now favours requester 1; a bare reset pulse must return it to 0.
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        chk("ptr_rst_vld0", 8'(rd_vld0), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        rd_req0 = 1; rd_addr0 = 8'h0A; rd_req1 = 1; rd_addr1 = 8'h0B;
        #1;
        chk("ptr_rst_g0", 8'(rd_gnt0), 8'h01);
        chk("ptr_rst_g1", 8'(rd_gnt1), 8'h00);
        @(negedge clk);
        idle();
        #1;
        chk("ptr_rst_vld0b", 8'(rd_vld0), 8'h01);
        chk("ptr_rst_data", rd_data, 8'h8A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
